// File: rtl/uart_app_pkg.sv
// -----------------------------------------------------------------------------
// uart_app_pkg
//
// Purpose:
//   Shared constants and types for the timestamp-to-UART report path.
//   - FRAME_LEN       : number of bytes in one report frame.
//   - ASCII_*         : the character constants used to build a frame.
//   - *_MSB / *_LSB   : bit positions of each field inside the packed tstamp.
//   - state_t         : frame-sender state enumeration.
// -----------------------------------------------------------------------------
package uart_app_pkg;

    localparam int FRAME_LEN = 16;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Packed time layout: {mon, day, hr, min, sec}; mon and day are zero-based.
    localparam int TS_W    = 26;
    localparam int MON_MSB = 25;
    localparam int MON_LSB = 22;
    localparam int DAY_MSB = 21;
    localparam int DAY_LSB = 17;
    localparam int HR_MSB  = 16;
    localparam int HR_LSB  = 12;
    localparam int MIN_MSB = 11;
    localparam int MIN_LSB = 6;
    localparam int SEC_MSB = 5;
    localparam int SEC_LSB = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_ascii2.sv
// -----------------------------------------------------------------------------
// bin_to_ascii2
//
// Purpose:
//   Combinational conversion of a 6-bit value (0..63) into two ASCII decimal
//   digits. Values 60..63 are rendered faithfully ("60".."63").
//
// Ports:
//   value        in   6  binary value to render
//   tens_ascii   out  8  ASCII tens digit ('0'..'6')
//   units_ascii  out  8  ASCII units digit ('0'..'9')
// -----------------------------------------------------------------------------
module bin_to_ascii2
    import uart_app_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens_ascii,
    output logic [7:0] units_ascii
);

    logic [5:0] tens;
    logic [5:0] units;

    // Division by a constant over a 6-bit range collapses to a small lookup.
    // tens never exceeds 6, so tens*10 fits comfortably in 6 bits.
    always_comb begin
        tens  = value / 6'd10;
        units = value - 6'(tens * 6'd10);
    end

    assign tens_ascii  = ASCII_ZERO + {2'b00, tens};
    assign units_ascii = ASCII_ZERO + {2'b00, units};

endmodule

// File: rtl/tstamp_frame_tx.sv
// -----------------------------------------------------------------------------
// tstamp_frame_tx
//
// Purpose:
//   On each rising edge of enable_pulse (arriving from the ticker domain),
//   captures the packed timestamp and streams the 16-byte ASCII frame
//   "MM/DD HH:MM:SS\r\n" to a UART transmitter with a valid/ready handshake.
//   Month and day are displayed one-based; the other fields are raw.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops on enable_pulse (must be >= 2)
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   enable_pulse  in   1   report trigger, asynchronous to clk
//   tstamp        in   26  {mon, day, hr, min, sec}
//   tx_data       out  8   ASCII byte offered to the transmitter
//   tx_valid      out  1   tx_data is valid
//   tx_ready      in   1   transmitter accepts a byte this cycle
//   busy          out  1   high while a frame is being sent
//   frame_done    out  1   one-cycle pulse after the last byte is accepted
//   overrun       out  1   one-cycle pulse when a trigger is dropped
// -----------------------------------------------------------------------------
module tstamp_frame_tx
    import uart_app_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_pulse,
    input  logic [TS_W-1:0] tstamp,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);

    // ------------------------------------------------------------------
    // Trigger synchronizer and rising-edge detector.
    // All flops preset to 1 so a level already high at reset release is
    // not mistaken for a fresh rising edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   trigger;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
            edge_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], enable_pulse};
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign trigger = sync_reg[SYNC_STAGES-1] & ~edge_reg;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t     state_reg;
    logic [3:0] idx_reg;
    logic [7:0] tx_data_reg;
    logic       tx_valid_reg;
    logic       frame_done_reg;
    logic       overrun_reg;

    // Timestamp fields captured at trigger; the frame is built only from
    // these so tstamp may change freely while a frame is in flight.
    logic [MON_MSB-MON_LSB:0] mon_reg;
    logic [DAY_MSB-DAY_LSB:0] day_reg;
    logic [HR_MSB-HR_LSB:0]   hr_reg;
    logic [MIN_MSB-MIN_LSB:0] min_reg;
    logic [SEC_MSB-SEC_LSB:0] sec_reg;

    // ------------------------------------------------------------------
    // Field rendering: index 0..4 = month, day, hour, minute, second.
    // ------------------------------------------------------------------
    logic [5:0] field_val   [5];
    logic [7:0] field_tens  [5];
    logic [7:0] field_units [5];

    assign field_val[0] = {2'b00, mon_reg} + 6'd1;
    assign field_val[1] = {1'b0, day_reg} + 6'd1;
    assign field_val[2] = {1'b0, hr_reg};
    assign field_val[3] = min_reg;
    assign field_val[4] = sec_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_conv
            bin_to_ascii2 u_conv (
                .value       (field_val[gi]),
                .tens_ascii  (field_tens[gi]),
                .units_ascii (field_units[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame byte table and 16-way selection
    // ------------------------------------------------------------------
    logic [7:0] frame_bytes [FRAME_LEN];
    logic [3:0] next_idx;
    logic [7:0] next_byte;
    logic [7:0] first_byte;
    logic       xfer;

    always_comb begin
        frame_bytes[0]  = field_tens[0];
        frame_bytes[1]  = field_units[0];
        frame_bytes[2]  = ASCII_SLASH;
        frame_bytes[3]  = field_tens[1];
        frame_bytes[4]  = field_units[1];
        frame_bytes[5]  = ASCII_SPACE;
        frame_bytes[6]  = field_tens[2];
        frame_bytes[7]  = field_units[2];
        frame_bytes[8]  = ASCII_COLON;
        frame_bytes[9]  = field_tens[3];
        frame_bytes[10] = field_units[3];
        frame_bytes[11] = ASCII_COLON;
        frame_bytes[12] = field_tens[4];
        frame_bytes[13] = field_units[4];
        frame_bytes[14] = ASCII_CR;
        frame_bytes[15] = ASCII_LF;
    end

    assign next_idx  = idx_reg + 4'd1;
    assign next_byte = frame_bytes[next_idx];
    assign xfer      = tx_valid_reg & tx_ready;

    // Byte 0 must be on tx_data in the cycle right after the trigger, before
    // the captured fields reach the converters. It is the tens digit of
    // mon+1, which (mon being 0..15) is '1' exactly when mon >= 9.
    assign first_byte = (tstamp[MON_MSB:MON_LSB] >= 4'd9) ? (ASCII_ZERO + 8'd1)
                                                          : ASCII_ZERO;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= 4'd0;
            tx_data_reg    <= 8'h00;
            tx_valid_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            mon_reg        <= '0;
            day_reg        <= '0;
            hr_reg         <= '0;
            min_reg        <= '0;
            sec_reg        <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        mon_reg      <= tstamp[MON_MSB:MON_LSB];
                        day_reg      <= tstamp[DAY_MSB:DAY_LSB];
                        hr_reg       <= tstamp[HR_MSB:HR_LSB];
                        min_reg      <= tstamp[MIN_MSB:MIN_LSB];
                        sec_reg      <= tstamp[SEC_MSB:SEC_LSB];
                        idx_reg      <= 4'd0;
                        tx_data_reg  <= first_byte;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Any trigger while sending is dropped, including one
                    // coinciding with the final byte transfer.
                    if (trigger) begin
                        overrun_reg <= 1'b1;
                    end
                    if (xfer) begin
                        if (idx_reg == 4'(FRAME_LEN - 1)) begin
                            tx_valid_reg   <= 1'b0;
                            frame_done_reg <= 1'b1;
                            state_reg      <= ST_IDLE;
                        end else begin
                            idx_reg     <= next_idx;
                            tx_data_reg <= next_byte;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign busy       = (state_reg == ST_SEND);
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_tstamp_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_tstamp_frame_tx
//
// Scoreboard bench: each task that triggers a frame pushes the 16 expected
// bytes; a negedge monitor pops one entry per accepted byte and also checks
// the frame_done pulse that must follow the last byte.
// -----------------------------------------------------------------------------
module tb_tstamp_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_pulse;
    logic [25:0] tstamp;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    always #5 clk = ~clk;

    tstamp_frame_tx #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_pulse (enable_pulse),
        .tstamp       (tstamp),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt     = 0;
    int   total_cnt    = 0;
    int   bytes_seen   = 0;
    int   done_cnt     = 0;
    int   ovr_cnt      = 0;
    bit   done_pending = 1'b0;

    function automatic logic [25:0] pack_ts(int mon, int day, int hr, int mn, int sec);
        return 26'((mon << 22) | (day << 17) | (hr << 12) | (mn << 6) | sec);
    endfunction

    // Expected frame, built directly from the textual format.
    task automatic push_frame(input logic [25:0] ts);
        int         f[5];
        logic [7:0] b[$];
        exp_t       e;
        f[0] = int'(ts[25:22]) + 1;
        f[1] = int'(ts[21:17]) + 1;
        f[2] = int'(ts[16:12]);
        f[3] = int'(ts[11:6]);
        f[4] = int'(ts[5:0]);
        b = {};
        for (int i = 0; i < 5; i++) begin
            b.push_back(8'(48 + f[i] / 10));
            b.push_back(8'(48 + f[i] % 10));
            if (i == 0)      b.push_back(8'h2F);
            else if (i == 1) b.push_back(8'h20);
            else if (i < 4)  b.push_back(8'h3A);
        end
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        for (int k = 0; k < b.size(); k++) begin
            e.data = b[k];
            e.last = (k == b.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (overrun === 1'b1)    ovr_cnt++;
        if (rst === 1'b0) begin
            if (done_pending) begin
                total_cnt++;
                if (frame_done !== 1'b1 || tx_valid !== 1'b0)
                    $display("FAIL frame_end: frame_done=%b tx_valid=%b, required frame_done=1 tx_valid=0",
                             frame_done, tx_valid);
                else
                    pass_cnt++;
                done_pending = 1'b0;
            end else if (frame_done === 1'b1) begin
                total_cnt++;
                $display("FAIL spurious_frame_done: frame_done=1, required 0");
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_byte: got 0x%02h, required no byte", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tx_data !== mon_e.data)
                        $display("FAIL byte_%0d: got 0x%02h, required 0x%02h",
                                 bytes_seen, tx_data, mon_e.data);
                    else
                        pass_cnt++;
                    if (mon_e.last) done_pending = 1'b1;
                end
                $display("byte %0d data=0x%02h", bytes_seen, tx_data);
                bytes_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enable();
        enable_pulse = 1'b1;
        repeat (4) tick();
        enable_pulse = 1'b0;
    endtask

    task automatic trigger_frame(input logic [25:0] ts);
        tstamp = ts;
        push_frame(ts);
        pulse_enable();
    endtask

    task automatic wait_bytes(input int n, input string name);
        for (int k = 0; k < 400 && bytes_seen < n; k++) tick();
        if (bytes_seen < n) begin
            total_cnt++;
            $display("FAIL %s_timeout: bytes_seen=%0d, required %0d", name, bytes_seen, n);
        end
    endtask

    task automatic wait_frame_end(input string name);
        for (int k = 0; k < 400 && (exp_q.size() != 0 || busy !== 1'b0); k++) tick();
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            total_cnt++;
            $display("FAIL %s_timeout: %0d bytes outstanding busy=%b, required 0 and 0",
                     name, exp_q.size(), busy);
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable_pulse = 1'b0;
        tx_ready = 1'b1;
        tstamp = '0;
        repeat (3) tick();
        @(negedge clk);
        total_cnt++;
        if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b, required 0", tx_valid);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done);
        else pass_cnt++;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, required 0", overrun);
        else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got 0x%02h, required 0x00", tx_data);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        int base = bytes_seen;
        int d0 = done_cnt;
        int o0 = ovr_cnt;
        tstamp = 26'h09C93C0;
        push_frame(tstamp);
        enable_pulse = 1'b1;
        wait_bytes(base + 1, "basic_start");
        repeat (15) tick();
        total_cnt++;
        if (bytes_seen !== base + 16)
            $display("FAIL basic_consecutive: got %0d bytes in 16 cycles, required 16", bytes_seen - base);
        else pass_cnt++;
        enable_pulse = 1'b0;
        wait_frame_end("basic");
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL basic_done_count: got %0d, required %0d", done_cnt - d0, 1);
        else pass_cnt++;
        total_cnt++;
        if (ovr_cnt !== o0) $display("FAIL basic_overrun: got %0d pulses, required 0", ovr_cnt - o0);
        else pass_cnt++;
    endtask

    task automatic test_max_fields();
        int d0 = done_cnt;
        trigger_frame(pack_ts(11, 29, 23, 59, 60));
        // Frame is in flight; disturbing tstamp must not affect it.
        tstamp = 26'h3FFFFFF;
        wait_frame_end("max_fields");
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL max_done_count: got %0d, required 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int base = bytes_seen;
        tstamp = 26'h09C93C0;
        push_frame(tstamp);
        enable_pulse = 1'b1;
        wait_bytes(base + 6, "stall_reach");
        enable_pulse = 1'b0;
        tx_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++;
            if (tx_data !== 8'h30 || tx_valid !== 1'b1)
                $display("FAIL stall_hold_%0d: tx_data=0x%02h tx_valid=%b, required 0x30 and 1",
                         c, tx_data, tx_valid);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        total_cnt++;
        if (bytes_seen !== base + 6)
            $display("FAIL stall_no_transfer: got %0d bytes, required 6", bytes_seen - base);
        else pass_cnt++;
        wait_frame_end("stall");
    endtask

    task automatic test_overrun();
        int base = bytes_seen;
        int d0 = done_cnt;
        int o0 = ovr_cnt;
        tstamp = pack_ts(6, 3, 17, 42, 7);
        push_frame(tstamp);
        enable_pulse = 1'b1;
        wait_bytes(base + 3, "overrun_start");
        enable_pulse = 1'b0;
        wait_bytes(base + 8, "overrun_reach");
        tstamp = pack_ts(1, 1, 1, 1, 1);
        pulse_enable();
        wait_frame_end("overrun");
        repeat (30) tick();
        total_cnt++;
        if (ovr_cnt !== o0 + 1) $display("FAIL overrun_count: got %0d, required 1", ovr_cnt - o0);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL overrun_done_count: got %0d, required 1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (bytes_seen !== base + 16 || busy !== 1'b0)
            $display("FAIL overrun_no_second_frame: bytes=%0d busy=%b, required 16 and 0",
                     bytes_seen - base, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int base = bytes_seen;
        int d0 = done_cnt;
        tstamp = pack_ts(4, 20, 8, 5, 33);
        push_frame(tstamp);
        enable_pulse = 1'b1;
        wait_bytes(base + 10, "rst_mid_reach");
        enable_pulse = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total_cnt++;
        if (tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_mid_abort: tx_valid=%b busy=%b, required 0 and 0", tx_valid, busy);
        else pass_cnt++;
        repeat (5) tick();
        total_cnt++;
        if (done_cnt !== d0) $display("FAIL rst_mid_no_done: got %0d pulses, required 0", done_cnt - d0);
        else pass_cnt++;
        trigger_frame(pack_ts(0, 0, 0, 0, 9));
        wait_frame_end("rst_mid_retry");
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL rst_mid_retry_done: got %0d, required 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_enable_high_at_reset();
        int base;
        int d0 = done_cnt;
        enable_pulse = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        base = bytes_seen;
        repeat (20) tick();
        @(negedge clk);
        total_cnt++;
        if (bytes_seen !== base || busy !== 1'b0)
            $display("FAIL enable_high_no_frame: bytes=%0d busy=%b, required 0 and 0",
                     bytes_seen - base, busy);
        else pass_cnt++;
        tick();
        enable_pulse = 1'b0;
        repeat (4) tick();
        trigger_frame(pack_ts(9, 0, 12, 30, 45));
        wait_frame_end("enable_high_retrigger");
        total_cnt++;
        if (done_cnt !== d0 + 1) $display("FAIL enable_high_done: got %0d, required 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        for (int n = 0; n < 3; n++) begin
            trigger_frame(26'($urandom()));
            wait_frame_end("back_to_back");
        end
        total_cnt++;
        if (done_cnt !== d0 + 3) $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        enable_pulse = 1'b0;
        tx_ready = 1'b1;
        tstamp = '0;
        test_reset();
        test_basic();
        test_max_fields();
        test_stall();
        test_overrun();
        test_reset_mid_frame();
        test_enable_high_at_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
